// File: rtl/dekoder_pkg.sv
// Shared definitions for the sequential instruction decoder.
// Holds the FSM state encoding, the execution-length classes, the
// control-word bit-field layout, the opcode constants and a saturating
// increment helper for the 8-bit EXEC wait counter.
package dekoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2
    } state_t;

    // How long an instruction stays in EXEC
    typedef enum logic [1:0] {
        EK_SINGLE = 2'd0,   // exactly one cycle
        EK_MEM    = 2'd1,   // 1 + MEM_WAIT cycles
        EK_ALU    = 2'd2    // until alu_done or timeout
    } exec_kind_t;

    // Datapath strobes; rw_* : 0 = read, 1 = write
    typedef struct packed {
        logic ldi;
        logic rf_ce;
        logic aku_ce;
        logic pamiec_ce;
        logic rw_rf;
        logic rw_pamiec;
        logic jmp_en;
        logic ce_wejsc;
        logic ce_wyjsc;
        logic rst_req;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    localparam logic [4:0] OPC_LD_REG_BIT = 5'd0;
    localparam logic [4:0] OPC_LD_AKU_REG = 5'd1;
    localparam logic [4:0] OPC_ST_AKU_REG = 5'd2;
    localparam logic [4:0] OPC_MOV_REG    = 5'd3;
    localparam logic [4:0] OPC_ADD        = 5'd4;
    localparam logic [4:0] OPC_SUB        = 5'd5;
    localparam logic [4:0] OPC_AND        = 5'd6;
    localparam logic [4:0] OPC_OR         = 5'd7;
    localparam logic [4:0] OPC_XOR        = 5'd8;
    localparam logic [4:0] OPC_NOT        = 5'd9;
    localparam logic [4:0] OPC_CMP        = 5'd10;
    localparam logic [4:0] OPC_INC_REG    = 5'd11;
    localparam logic [4:0] OPC_DEC_REG    = 5'd12;
    localparam logic [4:0] OPC_LD_PAM     = 5'd13;
    localparam logic [4:0] OPC_ST_PAM     = 5'd14;
    localparam logic [4:0] OPC_LDI        = 5'd15;
    localparam logic [4:0] OPC_SHL        = 5'd16;
    localparam logic [4:0] OPC_SHR        = 5'd17;
    localparam logic [4:0] OPC_MUL        = 5'd18;
    localparam logic [4:0] OPC_DIV        = 5'd19;
    localparam logic [4:0] OPC_MOD        = 5'd20;
    localparam logic [4:0] OPC_ROL        = 5'd21;
    localparam logic [4:0] OPC_ROR        = 5'd22;
    localparam logic [4:0] OPC_ADC        = 5'd23;
    localparam logic [4:0] OPC_SBC        = 5'd24;
    localparam logic [4:0] OPC_NEG        = 5'd25;
    localparam logic [4:0] OPC_SWAP       = 5'd26;
    localparam logic [4:0] OPC_JMP        = 5'd27;
    localparam logic [4:0] OPC_IN         = 5'd28;
    localparam logic [4:0] OPC_OUT        = 5'd29;
    localparam logic [4:0] OPC_RST        = 5'd30;
    localparam logic [4:0] OPC_NOP        = 5'd31;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            sat_inc8 = value;
        end else begin
            sat_inc8 = value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/dekoder_tab.sv
// Combinational opcode table.
// Ports:
//   opcode  in   OPCODE_W  captured opcode
//   ctrl    out  ctrl_t    datapath strobes for this opcode
//   instr   out  INSTR_W   ALU operation code (31 for undefined opcodes)
//   illegal out  1         opcode lies outside 0..31
module dekoder_tab
    import dekoder_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int INSTR_W  = 5
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic [INSTR_W-1:0]  instr,
    output logic                illegal
);

    localparam logic [INSTR_W-1:0] INSTR_IDLE = INSTR_W'(OPC_NOP);

    // Opcode -> control word; anything above 31 is a nop that raises illegal
    always_comb begin
        ctrl    = CTRL_NONE;
        instr   = INSTR_IDLE;
        illegal = 1'b0;
        if (opcode[OPCODE_W-1:5] != '0) begin
            illegal = 1'b1;
        end else begin
            instr = opcode[INSTR_W-1:0];
            case (opcode[4:0])
                OPC_LD_REG_BIT, OPC_LD_AKU_REG, OPC_ADD, OPC_SUB, OPC_AND,
                OPC_OR, OPC_XOR, OPC_NOT, OPC_CMP,
                OPC_SHL, OPC_SHR, OPC_MUL, OPC_DIV, OPC_MOD, OPC_ROL,
                OPC_ROR, OPC_ADC, OPC_SBC, OPC_NEG, OPC_SWAP: begin
                    ctrl.aku_ce = 1'b1;
                    ctrl.rf_ce  = 1'b1;
                end
                OPC_ST_AKU_REG, OPC_MOV_REG, OPC_INC_REG, OPC_DEC_REG: begin
                    ctrl.rf_ce = 1'b1;
                    ctrl.rw_rf = 1'b1;
                end
                OPC_LD_PAM: begin
                    ctrl.pamiec_ce = 1'b1;
                    ctrl.aku_ce    = 1'b1;
                end
                OPC_ST_PAM: begin
                    ctrl.pamiec_ce = 1'b1;
                    ctrl.rw_pamiec = 1'b1;
                end
                OPC_LDI: begin
                    ctrl.ldi    = 1'b1;
                    ctrl.aku_ce = 1'b1;
                end
                OPC_JMP: ctrl.jmp_en = 1'b1;
                OPC_IN: begin
                    ctrl.ce_wejsc = 1'b1;
                    ctrl.aku_ce   = 1'b1;
                end
                OPC_OUT: ctrl.ce_wyjsc = 1'b1;
                OPC_RST: ctrl.rst_req  = 1'b1;
                default: ctrl = CTRL_NONE;   // OPC_NOP
            endcase
        end
    end

endmodule

// File: rtl/dekoder_sekw.sv
// Sequential instruction decoder: IDLE -> DECODE -> EXEC -> IDLE.
// Every output is a register. Strobes for an EXEC cycle appear on the
// outputs in the following cycle, so the first strobe cycle starts two
// edges after the edge that accepted the opcode.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rom_valid, dane_rom      opcode offered by program ROM
//   rom_ready                decoder will take an opcode this cycle
//   alu_done                 multi-cycle ALU op finished (EXEC only)
//   instrukcja               ALU operation code, 31 when nothing executes
//   ldi .. ce_wyjsc          datapath strobes
//   rst_req                  one-cycle core soft-reset request
//   busy                     FSM is in DECODE or EXEC
//   illegal, timeout         one-cycle status pulses
module dekoder_sekw
    import dekoder_pkg::*;
#(
    parameter int OPCODE_W    = 8,
    parameter int INSTR_W     = 5,
    parameter int MEM_WAIT    = 1,
    parameter int ALU_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rom_valid,
    input  logic [OPCODE_W-1:0] dane_rom,
    output logic                rom_ready,
    input  logic                alu_done,
    output logic [INSTR_W-1:0]  instrukcja,
    output logic                ldi,
    output logic                rf_ce,
    output logic                aku_ce,
    output logic                pamiec_ce,
    output logic                rw_rf,
    output logic                rw_pamiec,
    output logic                jmp_en,
    output logic                ce_wejsc,
    output logic                ce_wyjsc,
    output logic                rst_req,
    output logic                busy,
    output logic                illegal,
    output logic                timeout
);

    localparam logic [INSTR_W-1:0] INSTR_IDLE = INSTR_W'(OPC_NOP);
    localparam logic [7:0]         MEM_LIMIT  = 8'(MEM_WAIT + 1);
    localparam logic [7:0]         ALU_LIMIT  = 8'(ALU_TIMEOUT);

    state_t               state_r;
    logic [OPCODE_W-1:0]  opc_r;
    logic [7:0]           cnt_r;
    exec_kind_t           kind_r;
    ctrl_t                ctrl_r;
    logic [INSTR_W-1:0]   instr_word_r;
    logic                 illegal_word_r;
    logic                 tmo_pend_r;

    ctrl_t                out_ctrl_r;
    logic [INSTR_W-1:0]   instr_out_r;
    logic                 illegal_r;
    logic                 timeout_r;
    logic                 busy_r;
    logic                 rom_ready_r;

    ctrl_t                tab_ctrl_s;
    logic [INSTR_W-1:0]   tab_instr_s;
    logic                 tab_illegal_s;
    exec_kind_t           kind_s;
    logic                 exec_end_s;
    logic                 exec_tmo_s;

    dekoder_tab #(
        .OPCODE_W (OPCODE_W),
        .INSTR_W  (INSTR_W)
    ) u_tab (
        .opcode  (opc_r),
        .ctrl    (tab_ctrl_s),
        .instr   (tab_instr_s),
        .illegal (tab_illegal_s)
    );

    // Classify the captured opcode by how long it occupies EXEC
    always_comb begin
        kind_s = EK_SINGLE;
        if (opc_r == OPCODE_W'(OPC_MUL) || opc_r == OPCODE_W'(OPC_DIV) ||
            opc_r == OPCODE_W'(OPC_MOD)) begin
            kind_s = EK_ALU;
        end else if (opc_r == OPCODE_W'(OPC_LD_PAM) ||
                     opc_r == OPCODE_W'(OPC_ST_PAM)) begin
            kind_s = EK_MEM;
        end else begin
            kind_s = EK_SINGLE;
        end
    end

    // Decide whether the current EXEC cycle is the last one; cnt_r counts
    // EXEC cycles starting at 1, so the limit equals the cycle budget
    always_comb begin
        exec_end_s = 1'b0;
        exec_tmo_s = 1'b0;
        case (kind_r)
            EK_MEM: begin
                if (cnt_r >= MEM_LIMIT) begin
                    exec_end_s = 1'b1;
                end else begin
                    exec_end_s = 1'b0;
                end
            end
            EK_ALU: begin
                if (alu_done) begin
                    exec_end_s = 1'b1;
                end else if (cnt_r >= ALU_LIMIT) begin
                    exec_end_s = 1'b1;
                    exec_tmo_s = 1'b1;
                end else begin
                    exec_end_s = 1'b0;
                end
            end
            default: exec_end_s = 1'b1;
        endcase
    end

    // Decoder FSM, wait counter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            opc_r          <= '0;
            cnt_r          <= 8'd0;
            kind_r         <= EK_SINGLE;
            ctrl_r         <= CTRL_NONE;
            instr_word_r   <= INSTR_IDLE;
            illegal_word_r <= 1'b0;
            tmo_pend_r     <= 1'b0;
            out_ctrl_r     <= CTRL_NONE;
            instr_out_r    <= INSTR_IDLE;
            illegal_r      <= 1'b0;
            timeout_r      <= 1'b0;
            busy_r         <= 1'b0;
            rom_ready_r    <= 1'b1;
        end else begin
            // pulse-type outputs fall back to idle values unless EXEC drives them
            out_ctrl_r  <= CTRL_NONE;
            instr_out_r <= INSTR_IDLE;
            illegal_r   <= 1'b0;
            // the timeout pulse follows the last strobe cycle of a stalled op
            timeout_r   <= tmo_pend_r;
            tmo_pend_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // rom_ready_r also stays low for the trailing strobe cycle,
                    // so an opcode is only taken when rom_ready is visible
                    if (rom_valid && rom_ready_r) begin
                        opc_r       <= dane_rom;
                        state_r     <= ST_DECODE;
                        busy_r      <= 1'b1;
                        rom_ready_r <= 1'b0;
                    end else begin
                        busy_r      <= 1'b0;
                        rom_ready_r <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    ctrl_r         <= tab_ctrl_s;
                    instr_word_r   <= tab_instr_s;
                    illegal_word_r <= tab_illegal_s;
                    kind_r         <= kind_s;
                    cnt_r          <= 8'd1;
                    state_r        <= ST_EXEC;
                    busy_r         <= 1'b1;
                    rom_ready_r    <= 1'b0;
                end
                ST_EXEC: begin
                    out_ctrl_r  <= ctrl_r;
                    instr_out_r <= instr_word_r;
                    illegal_r   <= illegal_word_r;
                    rom_ready_r <= 1'b0;
                    tmo_pend_r  <= exec_tmo_s;
                    if (exec_end_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r   <= sat_inc8(cnt_r);
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    rom_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign rom_ready  = rom_ready_r;
    assign busy       = busy_r;
    assign illegal    = illegal_r;
    assign timeout    = timeout_r;
    assign instrukcja = instr_out_r;
    assign ldi        = out_ctrl_r.ldi;
    assign rf_ce      = out_ctrl_r.rf_ce;
    assign aku_ce     = out_ctrl_r.aku_ce;
    assign pamiec_ce  = out_ctrl_r.pamiec_ce;
    assign rw_rf      = out_ctrl_r.rw_rf;
    assign rw_pamiec  = out_ctrl_r.rw_pamiec;
    assign jmp_en     = out_ctrl_r.jmp_en;
    assign ce_wejsc   = out_ctrl_r.ce_wejsc;
    assign ce_wyjsc   = out_ctrl_r.ce_wyjsc;
    assign rst_req    = out_ctrl_r.rst_req;

endmodule

// File: tb/tb_dekoder_sekw.sv
// Directed self-checking bench for dekoder_sekw (MEM_WAIT=3, ALU_TIMEOUT=15).
// Outputs are sampled 1 time unit after each rising edge.
module tb_dekoder_sekw;

    localparam logic [9:0] S_LDI   = 10'h200;
    localparam logic [9:0] S_RF    = 10'h100;
    localparam logic [9:0] S_AKU   = 10'h080;
    localparam logic [9:0] S_PAM   = 10'h040;
    localparam logic [9:0] S_RWRF  = 10'h020;
    localparam logic [9:0] S_RWPAM = 10'h010;
    localparam logic [9:0] S_JMP   = 10'h008;
    localparam logic [9:0] S_WEJ   = 10'h004;
    localparam logic [9:0] S_WYJ   = 10'h002;
    localparam logic [9:0] S_RST   = 10'h001;
    localparam logic [9:0] S_NONE  = 10'h000;

    logic       clk;
    logic       rst;
    logic       rom_valid;
    logic [7:0] dane_rom;
    logic       rom_ready;
    logic       alu_done;
    logic [4:0] instrukcja;
    logic       ldi, rf_ce, aku_ce, pamiec_ce, rw_rf, rw_pamiec;
    logic       jmp_en, ce_wejsc, ce_wyjsc, rst_req;
    logic       busy, illegal, timeout;
    logic [9:0] strb;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    dekoder_sekw #(
        .OPCODE_W    (8),
        .INSTR_W     (5),
        .MEM_WAIT    (3),
        .ALU_TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_valid  (rom_valid),
        .dane_rom   (dane_rom),
        .rom_ready  (rom_ready),
        .alu_done   (alu_done),
        .instrukcja (instrukcja),
        .ldi        (ldi),
        .rf_ce      (rf_ce),
        .aku_ce     (aku_ce),
        .pamiec_ce  (pamiec_ce),
        .rw_rf      (rw_rf),
        .rw_pamiec  (rw_pamiec),
        .jmp_en     (jmp_en),
        .ce_wejsc   (ce_wejsc),
        .ce_wyjsc   (ce_wyjsc),
        .rst_req    (rst_req),
        .busy       (busy),
        .illegal    (illegal),
        .timeout    (timeout)
    );

    assign strb = {ldi, rf_ce, aku_ce, pamiec_ce, rw_rf, rw_pamiec,
                   jmp_en, ce_wejsc, ce_wyjsc, rst_req};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer an opcode once rom_ready is seen; returns in the cycle after the accepting edge
    task automatic accept(input logic [7:0] op);
        int n;
        n = 0;
        while (rom_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk($sformatf("ready_before_op%0d", op), {31'd0, rom_ready}, 32'd1);
        rom_valid = 1'b1;
        dane_rom  = op;
        tick();
        rom_valid = 1'b0;
        dane_rom  = 8'h00;
    endtask

    // Single-cycle instruction: strobes exactly in cycle c3
    task automatic run_single(input logic [7:0] op, input logic [9:0] exp_strb,
                              input logic [4:0] exp_instr, input logic exp_ill);
        accept(op);
        chk($sformatf("op%0d_c1_busy", op), {31'd0, busy}, 32'd1);
        chk($sformatf("op%0d_c1_ready", op), {31'd0, rom_ready}, 32'd0);
        chk($sformatf("op%0d_c1_strb", op), {22'd0, strb}, 32'd0);
        tick();
        chk($sformatf("op%0d_c2_strb", op), {22'd0, strb}, 32'd0);
        chk($sformatf("op%0d_c2_busy", op), {31'd0, busy}, 32'd1);
        tick();
        chk($sformatf("op%0d_c3_strb", op), {22'd0, strb}, {22'd0, exp_strb});
        chk($sformatf("op%0d_c3_instr", op), {27'd0, instrukcja}, {27'd0, exp_instr});
        chk($sformatf("op%0d_c3_illegal", op), {31'd0, illegal}, {31'd0, exp_ill});
        chk($sformatf("op%0d_c3_busy", op), {31'd0, busy}, 32'd0);
        chk($sformatf("op%0d_c3_ready", op), {31'd0, rom_ready}, 32'd0);
        tick();
        chk($sformatf("op%0d_c4_strb", op), {22'd0, strb}, 32'd0);
        chk($sformatf("op%0d_c4_instr", op), {27'd0, instrukcja}, 32'd31);
        chk($sformatf("op%0d_c4_illegal", op), {31'd0, illegal}, 32'd0);
        chk($sformatf("op%0d_c4_ready", op), {31'd0, rom_ready}, 32'd1);
    endtask

    // Memory instruction with MEM_WAIT=3: strobes in c3..c6
    task automatic run_mem(input logic [7:0] op, input logic [9:0] exp_strb);
        accept(op);
        chk($sformatf("mem%0d_c1_ready", op), {31'd0, rom_ready}, 32'd0);
        tick();
        chk($sformatf("mem%0d_c2_strb", op), {22'd0, strb}, 32'd0);
        for (int k = 3; k <= 6; k++) begin
            tick();
            chk($sformatf("mem%0d_c%0d_strb", op, k), {22'd0, strb}, {22'd0, exp_strb});
            chk($sformatf("mem%0d_c%0d_ready", op, k), {31'd0, rom_ready}, 32'd0);
        end
        tick();
        chk($sformatf("mem%0d_c7_strb", op), {22'd0, strb}, 32'd0);
        chk($sformatf("mem%0d_c7_ready", op), {31'd0, rom_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_tmo;
        logic seen_strb;

        // reset held two cycles while ROM offers an opcode
        rst       = 1'b1;
        rom_valid = 1'b1;
        dane_rom  = 8'd6;
        alu_done  = 1'b0;
        tick();
        tick();
        chk("rst_strb", {22'd0, strb}, 32'd0);
        chk("rst_instr", {27'd0, instrukcja}, 32'd31);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, rom_ready}, 32'd1);
        chk("rst_flags", {30'd0, illegal, timeout}, 32'd0);
        rst       = 1'b0;
        rom_valid = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, rom_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_strb", {22'd0, strb}, 32'd0);

        // single-cycle opcodes, 6 then 28 back to back
        run_single(8'd6,   S_AKU | S_RF,   5'd6,  1'b0);
        run_single(8'd28,  S_WEJ | S_AKU,  5'd28, 1'b0);
        run_single(8'd0,   S_AKU | S_RF,   5'd0,  1'b0);
        run_single(8'd2,   S_RF | S_RWRF,  5'd2,  1'b0);
        run_single(8'd12,  S_RF | S_RWRF,  5'd12, 1'b0);
        run_single(8'd15,  S_LDI | S_AKU,  5'd15, 1'b0);
        run_single(8'd26,  S_AKU | S_RF,   5'd26, 1'b0);
        run_single(8'd27,  S_JMP,          5'd27, 1'b0);
        run_single(8'd29,  S_WYJ,          5'd29, 1'b0);
        run_single(8'd30,  S_RST,          5'd30, 1'b0);
        run_single(8'd31,  S_NONE,         5'd31, 1'b0);
        run_single(8'd40,  S_NONE,         5'd31, 1'b1);
        run_single(8'd255, S_NONE,         5'd31, 1'b1);
        run_single(8'd32,  S_NONE,         5'd31, 1'b1);

        // memory ops held 1+MEM_WAIT = 4 cycles
        run_mem(8'd14, S_PAM | S_RWPAM);
        run_mem(8'd13, S_PAM | S_AKU);

        // opcode 19, alu_done in 5th EXEC cycle (c6); alu_done in DECODE ignored
        accept(8'd19);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("div_c2_strb", {22'd0, strb}, 32'd0);
        for (int k = 3; k <= 7; k++) begin
            tick();
            alu_done = (k == 6) ? 1'b1 : 1'b0;
            chk($sformatf("div_c%0d_strb", k), {22'd0, strb}, {22'd0, S_AKU | S_RF});
            chk($sformatf("div_c%0d_instr", k), {27'd0, instrukcja}, 32'd19);
            chk($sformatf("div_c%0d_tmo", k), {31'd0, timeout}, 32'd0);
        end
        tick();
        chk("div_c8_strb", {22'd0, strb}, 32'd0);
        chk("div_c8_tmo", {31'd0, timeout}, 32'd0);
        tick();
        chk("div_c9_tmo", {31'd0, timeout}, 32'd0);

        // opcode 19 without alu_done: 15 strobe cycles, then timeout pulse
        accept(8'd19);
        for (int k = 2; k <= 17; k++) begin
            tick();
            chk($sformatf("tmo_c%0d_strb", k), {22'd0, strb},
                (k >= 3) ? {22'd0, S_AKU | S_RF} : 32'd0);
            chk($sformatf("tmo_c%0d_tmo", k), {31'd0, timeout}, 32'd0);
        end
        tick();
        chk("tmo_c18_tmo", {31'd0, timeout}, 32'd1);
        chk("tmo_c18_strb", {22'd0, strb}, 32'd0);
        tick();
        chk("tmo_c19_tmo", {31'd0, timeout}, 32'd0);

        // opcode 18, rst during its 2nd EXEC cycle (c3)
        accept(8'd18);
        tick();
        tick();
        chk("mul_c3_strb", {22'd0, strb}, {22'd0, S_AKU | S_RF});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mul_rst_strb", {22'd0, strb}, 32'd0);
        chk("mul_rst_busy", {31'd0, busy}, 32'd0);
        chk("mul_rst_ready", {31'd0, rom_ready}, 32'd1);
        chk("mul_rst_instr", {27'd0, instrukcja}, 32'd31);
        seen_tmo  = 1'b0;
        seen_strb = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen_tmo  = seen_tmo | timeout;
            seen_strb = seen_strb | (|strb);
        end
        chk("mul_rst_no_tmo", {31'd0, seen_tmo}, 32'd0);
        chk("mul_rst_no_strb", {31'd0, seen_strb}, 32'd0);

        // decoder still works after the abort
        run_single(8'd5, S_AKU | S_RF, 5'd5, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dekoder_sekw.md
DEKODER_SEKW -- requirements
Module: dekoder_sekw

Interface
REQ-001 Parameter OPCODE_W, default 8, width of the fetched opcode byte.
REQ-002 Parameter INSTR_W, default 5, width of the instrukcja code to the ALU; SHALL be >= 5 and < OPCODE_W.
REQ-003 Parameter MEM_WAIT, default 1, extra EXEC cycles held for ld_pam/st_pam (0..15).
REQ-004 Parameter ALU_TIMEOUT, default 15, max EXEC cycles waiting on alu_done for mul/div/mod (1..255).
REQ-005 Ports (name  direction  width  meaning):
 clk  in  1  single system clock, all state on rising edge
 rst  in  1  synchronous, active-high reset
 rom_valid  in  1  opcode available from program ROM
 dane_rom  in  OPCODE_W  opcode from ROM
 rom_ready  out  1  decoder can accept an opcode
 alu_done  in  1  multi-cycle ALU op finished
 instrukcja  out  INSTR_W  ALU operation code
 ldi, rf_ce, aku_ce, pamiec_ce, rw_rf, rw_pamiec, jmp_en, ce_wejsc, ce_wyjsc  out  1 each  datapath strobes; rw_* 0=read, 1=write
 rst_req  out  1  core soft-reset request (one cycle)
 busy  out  1  high in any state other than IDLE
 illegal  out  1  one-cycle pulse on an undefined opcode
 timeout  out  1  one-cycle pulse when ALU wait expires

Function
REQ-006 States IDLE, DECODE, EXEC; all outputs registered.
REQ-007 IDLE: rom_ready=1; on rom_valid=1 capture dane_rom, go DECODE; otherwise stay.
REQ-008 rom_ready SHALL be 0 in DECODE and EXEC; rom_valid there is ignored.
REQ-009 DECODE lasts exactly one cycle; the control word is computed and registered; go EXEC.
REQ-010 Latency: strobes are high in the cycle that starts two edges after the accepting edge.
REQ-011 Control words, all unlisted strobes 0: opcodes 0,1,4..10 aku_ce+rf_ce; 2,3,11,12 rf_ce+rw_rf; 13 pamiec_ce+aku_ce; 14 pamiec_ce+rw_pamiec; 15 ldi+aku_ce; 16..26 aku_ce+rf_ce; 27 jmp_en; 28 ce_wejsc+aku_ce; 29 ce_wyjsc; 30 rst_req; 31 none (nop).
REQ-012 instrukcja = dane_rom[INSTR_W-1:0] for opcodes 0..31, else 31.
REQ-013 Opcodes >= 32: all strobes 0, instrukcja=31, illegal pulses during the EXEC cycle.
REQ-014 EXEC for single-cycle ops lasts one cycle, then IDLE.
REQ-015 Opcodes 13,14: strobes held 1+MEM_WAIT cycles, then IDLE.
REQ-016 Opcodes 18,19,20: strobes held until alu_done=1 is sampled in EXEC, return to IDLE the next cycle; alu_done in the first EXEC cycle ends EXEC after that cycle.
REQ-017 If alu_done is not seen within ALU_TIMEOUT EXEC cycles: timeout pulses one cycle, strobes drop, go IDLE.
REQ-018 rst_req (opcode 30) is high only in its single EXEC cycle; the decoder itself does not reset on it.
REQ-019 The EXEC wait counter is 8 bits, loaded on DECODE exit, and never wraps (saturates at the limit).
REQ-020 alu_done outside EXEC is ignored.

Reset
REQ-021 rst=1 at a clock edge forces IDLE, clears captured opcode and counter, drives all strobes, rst_req, illegal, timeout and busy to 0, instrukcja to 31, and rom_ready to 1 from the next cycle.
REQ-022 rst mid-EXEC aborts the instruction with no further strobe cycles; rst takes priority over rom_valid and alu_done.

Structure
REQ-023 Shared package dekoder_pkg holds the state enumeration, opcode constants (LD_REG_BIT..NOP, 0..31), OPC_MUL/DIV/MOD, OPC_LD_PAM/ST_PAM, and the control-word bit-field layout.
REQ-024 One combinational sub-module, dekoder_tab (opcode -> control word, illegal flag), is instantiated; the FSM and counter live in dekoder_sekw.

Verification
REQ-025 Reset: hold rst 2 cycles with rom_valid=1 -> all strobes 0, instrukcja=31, busy=0, rom_ready=1 after release.
REQ-026 Opcode 6 accepted at edge E -> aku_ce=rf_ce=1, instrukcja=6 for exactly one cycle after edge E+2; busy for 2 cycles; back-to-back opcode 28 -> ce_wejsc+aku_ce.
REQ-027 Opcode 14 with MEM_WAIT=3 -> pamiec_ce=rw_pamiec=1 for 4 cycles, rom_ready=0 throughout.
REQ-028 Opcode 19, alu_done on the 5th EXEC cycle -> strobes for 5 cycles, no timeout; repeat with alu_done never -> timeout pulse after 15 cycles.
REQ-029 Opcode 40 -> illegal single pulse, no strobes, instrukcja=31; opcode 30 -> rst_req one cycle.
REQ-030 rst asserted in the 2nd EXEC cycle of opcode 18 -> strobes 0 on the next cycle, IDLE, no timeout.
